ifetch_unit: RTL

//  Instruction-fetch stage feeding the main control decoder: holds the PC, fetches one word per

---
 rtl/ifetch_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
//   Instruction-fetch stage. Holds the PC and fetches one word per instruction
//   over a req/ack memory port. It presents that word as instr with a
//   one-per-instruction valid strobe. When the instruction is released, it
//   selects the next PC from the decoder's Jr/Jmp/Jal/Branch/nBranch outputs.
//   Misaligned next-PC targets and memory ack timeouts enter a sticky trap
//   state. Only reset leaves the trap state.
//
// Parameters
//   RESET_PC     PC loaded by reset (word aligned)
//   ACK_TIMEOUT  REQ cycles without imem_ack before trapping; 0 disables
//
// Ports
//   clock        in   1   rising-edge clock
//   reset_n      in   1   synchronous reset, active low
//   imem_req     out  1   fetch request (REQ state only)
//   imem_addr    out  32  fetch address, equals pc
//   imem_ack     in   1   imem_rdata valid this cycle (used only in REQ)
//   imem_rdata   in   32  fetched instruction word
//   instr        out  32  registered instruction word
//   instr_valid  out  1   instr/pc/link_addr valid (ISSUE state)
//   pc           out  32  address of the current instruction
//   link_addr    out  32  pc + 4
//   stall        in   1   holds ISSUE, freezes pc/instr
//   Jr,Jmp,Jal   in   1   decoder jump controls
//   Branch       in   1   beq decoded
//   nBranch      in   1   bne decoded
//   Zero         in   1   ALU equality flag
//   Read_data_1  in   32  jr target
//   Addr_result  in   32  branch target
//   fault        out  1   sticky trap flag
//   fault_code   out  2   00 none, 01 misaligned target, 10 fetch timeout
// ----------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic        stall,
    input  logic        Jr,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Zero,
    input  logic [31:0] Read_data_1,
    input  logic [31:0] Addr_result,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ISSUE,
        TRAP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_nx;
    logic [31:0] instr_nx;
    logic [31:0] count;
    logic [31:0] count_nx;
    logic [1:0]  code_nx;
    logic [31:0] target;
    logic        taken;

    assign link_addr   = pc + 32'd4;
    assign imem_req    = (state == REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == ISSUE);
    assign fault       = (state == TRAP);

    // Next-PC selection. Jr has the highest priority, then Jmp/Jal, then a
    // taken branch. When Branch and nBranch are both set, either condition
    // is enough for the branch to be taken.
    always_comb begin
        taken = (Branch && Zero) || (nBranch && !Zero);
        if (Jr) begin
            target = Read_data_1;
        end else if (Jmp || Jal) begin
            target = {link_addr[31:28], instr[25:0], 2'b00};
        end else if (taken) begin
            target = Addr_result;
        end else begin
            target = link_addr;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instr;
        count_nx = count;
        code_nx  = fault_code;
        case (state)
            IDLE: begin
                state_nx = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    instr_nx = imem_rdata;
                    count_nx = '0;
                    state_nx = ISSUE;
                end else begin
                    count_nx = count + 32'd1;
                    if ((ACK_TIMEOUT != 0) && (count_nx == ACK_TIMEOUT)) begin
                        state_nx = TRAP;
                        code_nx  = 2'b10;
                    end
                end
            end
            ISSUE: begin
                if (!stall) begin
                    // A misaligned target traps. The pc keeps the address
                    // of the instruction that produced the target.
                    if (target[1:0] != 2'b00) begin
                        state_nx = TRAP;
                        code_nx  = 2'b01;
                    end else begin
                        pc_nx    = target;
                        state_nx = REQ;
                    end
                end
            end
            TRAP: begin
                state_nx = TRAP;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr      <= '0;
            count      <= '0;
            fault_code <= 2'b00;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            instr      <= instr_nx;
            count      <= count_nx;
            fault_code <= code_nx;
        end
    end

endmodule
